// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width, byte type
// and a 2-of-3 majority helper. Used by both the receiver and transmitter.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_DATA    = 3'd2;
   localparam logic [2:0] S_STOP    = 3'd3;
   localparam logic [2:0] S_CLEANUP = 3'd4;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

   function automatic logic maj3(
      input logic a,
      input logic b,
      input logic c
   );
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, byte/strobes out.
// slave = receiver (uart_rx), master = the agent driving the line.
interface uart_rx_if;
   import uart_pkg::*;

   logic       i_Rx_Serial;
   logic       o_Rx_DV;
   uart_byte_t o_Rx_Byte;
   logic       o_Rx_Active;
   logic       o_Rx_Frame_Err;

   modport slave (
      input  i_Rx_Serial,
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Rx_Active,
      output o_Rx_Frame_Err
   );

   modport master (
      output i_Rx_Serial,
      input  o_Rx_DV,
      input  o_Rx_Byte,
      input  o_Rx_Active,
      input  o_Rx_Frame_Err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: i_Clock, i_Reset (sync, active-high, resets to 1), i_Async, o_Sync.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Async,
   output logic o_Sync
);

   logic ff1_q;
   logic ff2_q;

   // Reset to the idle line level so no false start is seen.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         ff1_q <= 1'b1;
         ff2_q <= 1'b1;
      end else begin
         ff1_q <= i_Async;
         ff2_q <= ff1_q;
      end
   end

   assign o_Sync = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: byte + one-cycle DV strobe, framing-error strobe.
// Ports: i_Clock, i_Reset (sync, active-high), rx_if (uart_rx_if.slave).
// Option: UART_RX_MAJORITY_EN -> 2-of-3 vote per bit (needs CLKS_PER_BIT>=8).
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1042
) (
   input  logic     i_Clock,
   input  logic     i_Reset,
   uart_rx_if.slave rx_if
);

   localparam logic [15:0] C_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] H_CNT  = 16'((CLKS_PER_BIT - 1) / 2);
   localparam logic [2:0]  IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic       rx_s;
   logic       bit_val;

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   uart_byte_t  shreg_q, shreg_d;
   uart_byte_t  byte_q, byte_d;
   logic        dv_q, dv_d;
   logic        ferr_q, ferr_d;
   logic        act_q, act_d;

   uart_rx_sync u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_Async (rx_if.i_Rx_Serial),
      .o_Sync  (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // Two earlier samples are captured two and one counts before the
   // decision count; the third vote is the live rx_s at decision time.
   logic [15:0] tgt;
   logic        m0_q;
   logic        m1_q;

   always_comb begin
      tgt = (state_q == S_START) ? H_CNT : C_LAST;
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         m0_q <= 1'b1;
         m1_q <= 1'b1;
      end else begin
         if (cnt_q == tgt - 16'd2) begin
            m0_q <= rx_s;
         end
         if (cnt_q == tgt - 16'd1) begin
            m1_q <= rx_s;
         end
      end
   end

   assign bit_val = maj3(m0_q, m1_q, rx_s);
`else
   assign bit_val = rx_s;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      byte_d  = byte_q;
      act_d   = act_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d = S_START;
               act_d   = 1'b1;
            end
         end

         // Mid-start-bit check rejects short glitches.
         S_START: begin
            if (cnt_q == H_CNT) begin
               cnt_d = '0;
               if (!bit_val) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
                  act_d   = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         S_DATA: begin
            if (cnt_q == C_LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = bit_val;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         S_STOP: begin
            if (cnt_q == C_LAST) begin
               cnt_d   = '0;
               state_d = S_CLEANUP;
               if (bit_val) begin
                  byte_d = shreg_q;
                  dv_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         // Wait for a high line so a break reports only once.
         S_CLEANUP: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
               act_d   = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            act_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
         act_q   <= act_d;
      end
   end

   assign rx_if.o_Rx_DV        = dv_q;
   assign rx_if.o_Rx_Byte      = byte_q;
   assign rx_if.o_Rx_Active    = act_q;
   assign rx_if.o_Rx_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// Reference: line waveform sampled at bit centres (or 3-sample vote).
module tb_uart_rx;
   import uart_pkg::*;

   localparam int C   = 16;
   localparam int MID = C / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_rx_if rx_if ();

   uart_rx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .rx_if   (rx_if.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int   dv_cnt   = 0;
   int   ferr_cnt = 0;
   int   both_cnt = 0;
   int   dv_cyc   = -1;
   int   act_cyc  = -1;
   logic act_prev = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   logic       wave[$];

   always @(negedge clk) begin
      if (rx_if.o_Rx_DV === 1'b1) begin
         dv_cnt++;
         dv_cyc = cyc;
         got_q.push_back(rx_if.o_Rx_Byte);
      end
      if (rx_if.o_Rx_Frame_Err === 1'b1) ferr_cnt++;
      if (rx_if.o_Rx_DV === 1'b1 && rx_if.o_Rx_Frame_Err === 1'b1)
         both_cnt++;
      if (rx_if.o_Rx_Active === 1'b1 && act_prev !== 1'b1)
         act_cyc = cyc;
      act_prev = rx_if.o_Rx_Active;
   end

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v);
      rx_if.i_Rx_Serial = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b1);
   endtask

   // Drive up to ncyc cycles of a frame; data bits get one inverted
   // cycle at offset g_off within each bit (g_off < 0: clean).
   task automatic send(input logic [7:0] b, input logic stop,
                       input int g_off, input int ncyc);
      int n;
      n = 0;
      wave.delete();
      for (int bi = 0; bi < 10; bi++) begin
         logic v;
         v = (bi == 0) ? 1'b0 : (bi == 9) ? stop : b[bi-1];
         for (int t = 0; t < C; t++) begin
            logic w;
            w = v;
            if (bi >= 1 && bi <= 8 && t == g_off) w = ~v;
            if (n < ncyc) begin
               wave.push_back(w);
               drive(w);
            end
            n++;
         end
      end
   endtask

   function automatic logic samp(input int base);
`ifdef UART_RX_MAJORITY_EN
      int ones;
      ones = int'(wave[base+MID-2]) + int'(wave[base+MID-1])
           + int'(wave[base+MID]);
      return ones >= 2;
`else
      return wave[base+MID];
`endif
   endfunction

   // {stop_ok, byte} as a receiver sampling the recorded line would see it.
   function automatic logic [8:0] model();
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = samp((k + 1) * C);
      return {samp(9 * C), b};
   endfunction

   initial begin
      int p, n0, f0, q0;
      logic [8:0] m;
      logic [7:0] rb;

      rx_if.i_Rx_Serial = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_dv",   32'(rx_if.o_Rx_DV), 0);
      chk("rst_byte", 32'(rx_if.o_Rx_Byte), 0);
      chk("rst_act",  32'(rx_if.o_Rx_Active), 0);
      chk("rst_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
      idle(C);

      // Single frame with timing
      n0 = dv_cnt;
      p  = cyc;
      send(8'hA5, 1'b1, -1, 10 * C);
      idle(C);
      chk("a5_cnt",  32'(dv_cnt - n0), 1);
      chk("a5_byte", 32'(rx_if.o_Rx_Byte), 32'h A5);
      chk("a5_act_e", 32'(act_cyc), 32'(p + 3));
      chk("a5_dv_t", 32'(dv_cyc),
          32'(p + 3 + (C - 1) / 2 + 9 * C + 1));
      chk("a5_idle", 32'(rx_if.o_Rx_Active), 0);

      // Back-to-back
      n0 = dv_cnt;
      f0 = ferr_cnt;
      q0 = got_q.size();
      send(8'h00, 1'b1, -1, 10 * C);
      send(8'hFF, 1'b1, -1, 10 * C);
      send(8'h3C, 1'b1, -1, 10 * C);
      idle(2 * C);
      chk("b2b_cnt",  32'(dv_cnt - n0), 3);
      chk("b2b_ferr", 32'(ferr_cnt - f0), 0);
      chk("b2b_0", 32'(got_q[q0]),     32'h00);
      chk("b2b_1", 32'(got_q[q0 + 1]), 32'hFF);
      chk("b2b_2", 32'(got_q[q0 + 2]), 32'h3C);

      // Short low glitch
      n0 = dv_cnt;
      f0 = ferr_cnt;
      repeat (4) drive(1'b0);
      idle(3 * C);
      chk("gl_dv",   32'(dv_cnt - n0), 0);
      chk("gl_ferr", 32'(ferr_cnt - f0), 0);
      chk("gl_act",  32'(rx_if.o_Rx_Active), 0);

      // Bad stop bit followed by break
      n0 = dv_cnt;
      f0 = ferr_cnt;
      send(8'h55, 1'b0, -1, 10 * C);
      repeat (40 * C) drive(1'b0);
      chk("brk_ferr", 32'(ferr_cnt - f0), 1);
      chk("brk_dv",   32'(dv_cnt - n0), 0);
      chk("brk_byte", 32'(rx_if.o_Rx_Byte), 32'h3C);
      chk("brk_act",  32'(rx_if.o_Rx_Active), 1);
      idle(C);
      chk("brk_rel",  32'(rx_if.o_Rx_Active), 0);
      send(8'h12, 1'b1, -1, 10 * C);
      idle(C);
      chk("brk_12",   32'(rx_if.o_Rx_Byte), 32'h12);
      chk("brk_12dv", 32'(dv_cnt - n0), 1);
      chk("brk_f1",   32'(ferr_cnt - f0), 1);

      // Reset in the middle of data bit 3
      n0 = dv_cnt;
      f0 = ferr_cnt;
      send(8'hF8, 1'b1, -1, 4 * C + MID);
      rx_if.i_Rx_Serial = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mr_dv",   32'(rx_if.o_Rx_DV), 0);
      chk("mr_byte", 32'(rx_if.o_Rx_Byte), 0);
      chk("mr_act",  32'(rx_if.o_Rx_Active), 0);
      chk("mr_ferr", 32'(rx_if.o_Rx_Frame_Err), 0);
      idle(8 * C);
      chk("mr_ndv",   32'(dv_cnt - n0), 0);
      chk("mr_nferr", 32'(ferr_cnt - f0), 0);

      // Glitch at count C-2 of every data bit
      send(8'hC3, 1'b1, MID - 1, 10 * C);
      m = model();
      idle(C);
      chk("g2_model", 32'(rx_if.o_Rx_Byte), 32'(m[7:0]));
      chk("g2_byte",  32'(rx_if.o_Rx_Byte), 32'hC3);

      // Glitch at count C-1 of every data bit
      send(8'hC3, 1'b1, MID, 10 * C);
      m = model();
      idle(C);
      chk("g1_model", 32'(rx_if.o_Rx_Byte), 32'(m[7:0]));
`ifdef UART_RX_MAJORITY_EN
      chk("g1_byte", 32'(rx_if.o_Rx_Byte), 32'hC3);
`else
      chk("g1_byte", 32'(rx_if.o_Rx_Byte), 32'h3C);
`endif

      // Random frames with unsampled glitches and random gaps
      n0 = dv_cnt;
      q0 = got_q.size();
      exp_q.delete();
      for (int i = 0; i < 24; i++) begin
         rb = 8'($urandom);
         send(rb, 1'b1, int'($urandom_range(0, MID - 3)), 10 * C);
         m = model();
         if (m[8]) exp_q.push_back(m[7:0]);
         idle(int'($urandom_range(0, 20)));
      end
      idle(2 * C);
      chk("rnd_cnt", 32'(dv_cnt - n0), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("rnd_%0d", i), 32'(got_q[q0 + i]),
             32'(exp_q[i]));
      end

      chk("dv_ferr_excl", 32'(both_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receives 8N1 asynchronous serial frames: one start bit, eight data bits LSB first, one stop bit, no parity. It reassembles each frame into a byte and presents it with a one-cycle valid strobe. It is the receive companion of the UART transmitter and shares its bit-period parameter, so both ends of a link are configured identically. Framing errors are flagged, and a held-low line (break) never produces repeated frames.

## Interface
- CLKS_PER_BIT, 1042, clock cycles per serial bit = f(i_Clock)/baud; legal range 4..65535
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- o_Rx_DV  out  1  one-cycle pulse: o_Rx_Byte holds a newly received byte
- o_Rx_Byte  out  8  last good byte; holds its value until the next good frame
- o_Rx_Active  out  1  high from start-bit detection until the FSM returns to IDLE
- o_Rx_Frame_Err  out  1  one-cycle pulse: stop bit sampled low

## Operation
- i_Rx_Serial passes through a 2-FF synchronizer; the FSM sees only the synchronized line (rx_s).
- C = CLKS_PER_BIT; H = (C-1)/2, integer division. Bit counter is 16 bits; bit index is 3 bits.
- IDLE: counter = 0, index = 0. When rx_s = 0, go to START and set o_Rx_Active.
- START: count up to H. At count H:
  - rx_s = 0: clear the counter, go to DATA.
  - rx_s = 1: glitch; go to IDLE, drop o_Rx_Active, no outputs pulsed.
- DATA: count 0..C-1. At C-1, shift the sampled bit into position [index], then:
  - index < 7: increment index.
  - index = 7: go to STOP.
- STOP: count 0..C-1, then sample the stop bit:
  - 1: load o_Rx_Byte from the shift register, pulse o_Rx_DV.
  - 0: pulse o_Rx_Frame_Err; o_Rx_Byte is unchanged.
  - Either way, go to CLEANUP.
- CLEANUP: hold until rx_s = 1, then go to IDLE and drop o_Rx_Active. A break therefore yields exactly one frame-error pulse.
- Reset has priority in every state, including mid-frame:
  - FSM goes to IDLE.
  - Synchronizer FFs go to 1.
  - o_Rx_DV = 0, o_Rx_Byte = 8'h00, o_Rx_Active = 0, o_Rx_Frame_Err = 0.
  - Shift register, counter and index go to 0.
- Illegal state encodings go to IDLE on the next clock.

## Timing
- Synchronizer latency is 2 cycles from the pin to rx_s.
- Let E be the clock edge at which the FSM enters START. Sampling points:
  - Start check at E+H.
  - Data bit k (k = 0..7) at E+H+(k+1)·C.
  - Stop bit at E+H+9·C.
- o_Rx_DV or o_Rx_Frame_Err is high for exactly the cycle after the stop sample. o_Rx_Byte is valid in that same cycle.
- o_Rx_DV and o_Rx_Frame_Err are never high together.
- A start bit arriving during CLEANUP after the line has returned high is detected. Back-to-back frames with no idle gap are received without loss.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Each bit decision is the 2-of-3 majority of rx_s at counts C-3, C-2 and C-1, decided at C-1.
  - The start check uses counts H-2, H-1 and H.
  - Requires C >= 8.
- Undefined: a single sample at the counts given in Operation.
- The sampling points and latency are identical in both builds.

## Structure
- Shared package uart_pkg:
  - State encoding localparams: S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP (3 bits).
  - UART_DATA_BITS = 8.
  - The same package serves the transmitter.
- One sub-module, uart_rx_sync: a 2-FF synchronizer with a synchronous reset value of 1. Everything else lives in uart_rx.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and a behavioural serial driver.
- Reset → all outputs 0 and o_Rx_Active = 0. Then send 8'hA5 → one o_Rx_DV pulse, o_Rx_Byte = 8'hA5, DV edge exactly at E+7+144+1.
- Back-to-back 8'h00, 8'hFF, 8'h3C with no idle gap → three DV pulses carrying those values in order, no frame error.
- Low pulse of 4 cycles on an idle line → return to IDLE, no DV, no Frame_Err.
- Frame 8'h55 with stop bit low, then line held low for 40 bit times → exactly one Frame_Err pulse, o_Rx_Byte keeps its previous value, no DV. After the line goes high, 8'h12 is received correctly.
- Reset asserted mid-frame at data bit 3 → next cycle: IDLE, all outputs 0. The rest of the aborted frame yields no DV or Frame_Err.
- With UART_RX_MAJORITY_EN: a 1-cycle inverted glitch at count C-2 of every data bit of 8'hC3 → o_Rx_Byte = 8'hC3.
- Without the macro: the same stimulus → o_Rx_Byte = 8'hC3, since no sample hits the glitch. A glitch placed at C-1 → the bench observes the flipped bits.
